btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Fetch-side branch target buffer with 2-bit saturating counters.
- Lookup path: predicts the next fetch PC from the current fetch PC.
- Update path: consumes branch resolution from the AD-stage pipeline latch (resolved PC, target, branch flag, and the prediction snapshot taken at fetch).
- Trains the table and raises a registered redirect on mispredict.

Parameters:
ENTRIES, 16, number of direct-mapped BTB entries (power of two)
IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]

Ports:
stg_clk  input  1  stage clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
stg_ena  input  1  stage enable; low = stall, all state holds
fetch_pc  input  32  current fetch address
pred_valid  output  1  lookup hit (entry valid, tag match)
pred_taken  output  1  hit and counter[1]==1
pred_counter  output  2  counter of hit entry, 0 on miss
pred_next_pc  output  32  pred_taken ? stored target : fetch_pc+4
upd_pc  input  32  PC of the resolved instruction
upd_target  input  32  resolved branch target
upd_flag  input  2  00 not branch, 01 branch not taken, 10 branch taken, 11 unconditional jump
upd_fetch_pc  input  32  next PC predicted at fetch for this instruction
upd_counter  input  2  counter snapshot from fetch
upd_valid  input  1  hit snapshot from fetch
upd_prediction  input  1  taken snapshot from fetch
redirect_valid  output  1  registered mispredict strobe
redirect_pc  output  32  registered correct next PC
stat_branches  output  32  see Optional Feature
stat_mispredicts  output  32  see Optional Feature

Behaviour:
- Lookup is combinational from table registers. There is no write-to-read bypass: a lookup in the same cycle as a write sees the old contents.
- Per entry state: valid, tag, target[31:0], counter[1:0].
- Reset: all valid=0, counters=00, redirect_valid=0, redirect_pc=0, stats=0. Lookup outputs then read pred_valid=0, pred_taken=0, pred_counter=0, pred_next_pc=fetch_pc+4.
- stg_ena=0: no table write, redirect regs and stats hold.
- Resolution: taken = (upd_flag==10 || upd_flag==11); actual_next = taken ? upd_target : upd_pc+4. All PC arithmetic is modulo 2^32; 0xFFFFFFFC+4 = 0.
- Update accepted when stg_ena=1 and shadow=0:
  - upd_flag!=00 and upd_valid=1: write tag from upd_pc and set valid. Counter becomes 11 for flag 11, else sat(upd_counter+1) if taken, sat(upd_counter-1) if not taken. Saturates at 11 and 00. Target is rewritten only when taken.
  - upd_flag!=00, upd_valid=0, taken: allocate (overwrite) entry. valid=1, tag, target, counter=10 (11 for jump).
  - upd_flag!=00, upd_valid=0, not taken: no table write.
  - upd_flag==00 and upd_prediction=1 (alias): invalidate entry at upd_pc index, mispredict with actual_next=upd_pc+4.
  - upd_flag==00 and upd_prediction=0: no action.
- Mispredict:
  - Condition: (upd_flag!=00 and actual_next!=upd_fetch_pc) or alias.
  - Next edge: redirect_valid=1, redirect_pc=actual_next.
  - Any accepted cycle without mispredict clears redirect_valid. The strobe therefore lasts exactly one enabled cycle.
- Shadow: while redirect_valid=1, the update inputs belong to the wrong path. They are ignored (no write, no redirect, no stats) and redirect_valid clears at the next enabled edge.
- Reset asserted mid-operation overrides everything in that cycle.

Optional Feature:
- BTB_STATS_EN defined: saturating 32-bit counters (stop at 0xFFFFFFFF).
  - stat_branches increments per accepted update with upd_flag!=00.
  - stat_mispredicts increments per accepted mispredict, including alias.
  - Both clear on reset.
- Undefined: counter logic is absent and both stat ports are tied to 0.

Test Plan:
1. Reset, then fetch_pc=0x100 -> pred_valid=0, pred_taken=0, pred_counter=00, pred_next_pc=0x104, redirect_valid=0.
2. Update upd_pc=0x100, flag=10, target=0x200, upd_valid=0, upd_fetch_pc=0x104:
   - Next cycle: redirect_valid=1, redirect_pc=0x200.
   - Lookup 0x100 -> hit, counter=10, pred_next_pc=0x200.
   - Following cycle: redirect_valid=0.
3. Counter saturation, with correct upd_fetch_pc so no redirect:
   - Two taken hits on 0x100 -> counter 11, then stays 11.
   - Then three not-taken hits -> 10, 01, 00; after the second, pred_taken=0 and pred_next_pc=0x104.
4. Alias: upd_pc=0x100, flag=00, upd_prediction=1 -> redirect_pc=0x104; lookup 0x100 -> pred_valid=0.
5. Shadow: two consecutive mispredicting updates (0x100->0x200 taken, then 0x300->0x400 taken, both miss) -> only redirect_pc=0x200 issued; lookup 0x300 -> miss.
6. Stall and reset:
   - stg_ena=0 with an allocating update -> no hit afterwards, redirect_valid unchanged.
   - reset=1 in the same cycle as an update -> table empty.
   - With BTB_STATS_EN: stats return to 0.

Source files
------------

// File: rtl/btb_predictor.sv
// Fetch-side direct-mapped branch target buffer with 2-bit saturating counters,
// AD-stage training and a registered mispredict redirect. Optional statistics: BTB_STATS_EN.
module btb_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic        stg_ena,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [1:0]  pred_counter,
    output logic [31:0] pred_next_pc,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_flag,
    input  logic [31:0] upd_fetch_pc,
    input  logic [1:0]  upd_counter,
    input  logic        upd_valid,
    input  logic        upd_prediction,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][31:0]      target_q;
    logic [ENTRIES-1:0][1:0]       counter_q;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             hit;

    // Lookup reads the table registers only: a same-cycle write is not visible.
    assign fetch_idx    = fetch_pc[IDX_W+1:2];
    assign fetch_tag    = fetch_pc[31:IDX_W+2];
    assign hit          = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_valid   = hit;
    assign pred_counter = hit ? counter_q[fetch_idx] : 2'b00;
    assign pred_taken   = hit && counter_q[fetch_idx][1];
    assign pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             is_branch;
    logic             taken;
    logic             alias_hit;
    logic             accept;
    logic             mispredict;
    logic [31:0]      actual_next;
    logic             wr_en;
    logic             wr_target;
    logic             inv_en;
    logic [1:0]       wr_counter;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign upd_idx     = upd_pc[IDX_W+1:2];
    assign upd_tag     = upd_pc[31:IDX_W+2];
    assign is_branch   = (upd_flag != 2'b00);
    assign taken       = upd_flag[1];
    assign alias_hit   = !is_branch && upd_prediction;
    assign actual_next = taken ? upd_target : upd_pc + 32'd4;
    // While a redirect is outstanding the update inputs are wrong-path and ignored.
    assign accept      = stg_ena && !redirect_valid;
    assign mispredict  = (is_branch && (actual_next != upd_fetch_pc)) || alias_hit;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Training decision for the resolved instruction.
    always_comb begin
        wr_en      = 1'b0;
        wr_target  = 1'b0;
        inv_en     = 1'b0;
        wr_counter = 2'b00;
        if (accept) begin
            if (is_branch) begin
                if (upd_valid) begin
                    wr_en      = 1'b1;
                    wr_target  = taken;
                    wr_counter = (upd_flag == 2'b11) ? 2'b11
                               : taken ? sat_inc(upd_counter) : sat_dec(upd_counter);
                end else if (taken) begin
                    wr_en      = 1'b1;
                    wr_target  = 1'b1;
                    wr_counter = (upd_flag == 2'b11) ? 2'b11 : 2'b10;
                end
            end else if (upd_prediction) begin
                inv_en = 1'b1;
            end
        end
    end

    always_ff @(posedge stg_clk) begin
        if (reset) begin
            valid_q        <= '0;
            tag_q          <= '0;
            target_q       <= '0;
            counter_q      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (stg_ena) begin
            if (wr_en) begin
                valid_q[upd_idx]   <= 1'b1;
                tag_q[upd_idx]     <= upd_tag;
                counter_q[upd_idx] <= wr_counter;
                if (wr_target) begin
                    target_q[upd_idx] <= upd_target;
                end
            end else if (inv_en) begin
                valid_q[upd_idx] <= 1'b0;
            end
            redirect_valid <= accept && mispredict;
            if (accept && mispredict) begin
                redirect_pc <= actual_next;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    // Saturating event counters for accepted, non-shadowed updates.
    always_ff @(posedge stg_clk) begin
        if (reset) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else if (accept) begin
            if (is_branch && (branches_q != 32'hFFFF_FFFF)) begin
                branches_q <= branches_q + 32'd1;
            end
            if (mispredict && (mispredicts_q != 32'hFFFF_FFFF)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: table of one-cycle update vectors plus
// hand sequences for stall, write-vs-lookup ordering and reset.
module tb_btb_predictor;

    logic        stg_clk = 1'b0;
    logic        reset;
    logic        stg_ena;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_counter;
    logic [31:0] pred_next_pc;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  upd_flag;
    logic [31:0] upd_fetch_pc;
    logic [1:0]  upd_counter;
    logic        upd_valid;
    logic        upd_prediction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks   = 0;
    int failures = 0;

    btb_predictor dut (
        .stg_clk          (stg_clk),
        .reset            (reset),
        .stg_ena          (stg_ena),
        .fetch_pc         (fetch_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_counter     (pred_counter),
        .pred_next_pc     (pred_next_pc),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_flag         (upd_flag),
        .upd_fetch_pc     (upd_fetch_pc),
        .upd_counter      (upd_counter),
        .upd_valid        (upd_valid),
        .upd_prediction   (upd_prediction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 stg_clk = ~stg_clk;

    typedef struct {
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [1:0]  uflag;
        logic [31:0] ufpc;
        logic [1:0]  ucnt;
        logic        uval;
        logic        upred;
        logic [31:0] fpc;
        logic        e_pv;
        logic [1:0]  e_cnt;
        logic [31:0] e_next;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [31:0] upc, input logic [31:0] utgt,
                                input logic [1:0] uflag, input logic [31:0] ufpc,
                                input logic [1:0] ucnt, input logic uval, input logic upred,
                                input logic [31:0] fpc, input logic e_pv, input logic [1:0] e_cnt,
                                input logic [31:0] e_next, input logic e_rv, input logic [31:0] e_rpc);
        vec_t v;
        v.upc = upc; v.utgt = utgt; v.uflag = uflag; v.ufpc = ufpc; v.ucnt = ucnt;
        v.uval = uval; v.upred = upred; v.fpc = fpc; v.e_pv = e_pv; v.e_cnt = e_cnt;
        v.e_next = e_next; v.e_rv = e_rv; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic pv, input logic [1:0] cnt,
                            input logic [31:0] nxt);
        chk({tag, ".pred_valid"},   32'(pred_valid),   32'(pv));
        chk({tag, ".pred_counter"}, 32'(pred_counter), 32'(cnt));
        chk({tag, ".pred_taken"},   32'(pred_taken),   32'(pv && cnt[1]));
        chk({tag, ".pred_next_pc"}, pred_next_pc,      nxt);
    endtask

    task automatic chk_redir(input string tag, input logic rv, input logic [31:0] rpc);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({tag, ".redirect_pc"},    redirect_pc,         rpc);
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
`ifdef BTB_STATS_EN
        chk({tag, ".stat_branches"},    stat_branches,    br);
        chk({tag, ".stat_mispredicts"}, stat_mispredicts, mp);
`else
        chk({tag, ".stat_branches"},    stat_branches,    32'd0);
        chk({tag, ".stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
    endtask

    task automatic drive_upd(input logic [31:0] upc, input logic [31:0] utgt,
                             input logic [1:0] uflag, input logic [31:0] ufpc,
                             input logic [1:0] ucnt, input logic uval, input logic upred);
        upd_pc = upc; upd_target = utgt; upd_flag = uflag; upd_fetch_pc = ufpc;
        upd_counter = ucnt; upd_valid = uval; upd_prediction = upred;
    endtask

    task automatic idle_upd();
        drive_upd(32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge stg_clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(32'h100, 32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h100, 0, 2'd0, 32'h104, 0, 32'h0);
        vecs[1]  = mk(32'h100, 32'h200, 2'b10, 32'h104, 2'd0, 0, 0, 32'h100, 1, 2'd2, 32'h200, 1, 32'h200);
        vecs[2]  = mk(32'h0,   32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h100, 1, 2'd2, 32'h200, 0, 32'h200);
        vecs[3]  = mk(32'h100, 32'h200, 2'b10, 32'h200, 2'd2, 1, 1, 32'h100, 1, 2'd3, 32'h200, 0, 32'h200);
        vecs[4]  = mk(32'h100, 32'h200, 2'b10, 32'h200, 2'd3, 1, 1, 32'h100, 1, 2'd3, 32'h200, 0, 32'h200);
        vecs[5]  = mk(32'h100, 32'h200, 2'b01, 32'h104, 2'd3, 1, 1, 32'h100, 1, 2'd2, 32'h200, 0, 32'h200);
        vecs[6]  = mk(32'h100, 32'h200, 2'b01, 32'h104, 2'd2, 1, 1, 32'h100, 1, 2'd1, 32'h104, 0, 32'h200);
        vecs[7]  = mk(32'h100, 32'h200, 2'b01, 32'h104, 2'd1, 1, 0, 32'h100, 1, 2'd0, 32'h104, 0, 32'h200);
        vecs[8]  = mk(32'h100, 32'h200, 2'b01, 32'h104, 2'd0, 1, 0, 32'h100, 1, 2'd0, 32'h104, 0, 32'h200);
        vecs[9]  = mk(32'h100, 32'h0,   2'b00, 32'h0,   2'd0, 0, 1, 32'h100, 0, 2'd0, 32'h104, 1, 32'h104);
        vecs[10] = mk(32'h0,   32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h100, 0, 2'd0, 32'h104, 0, 32'h104);
        vecs[11] = mk(32'h100, 32'h200, 2'b10, 32'h104, 2'd0, 0, 0, 32'h300, 0, 2'd0, 32'h304, 1, 32'h200);
        vecs[12] = mk(32'h300, 32'h400, 2'b10, 32'h304, 2'd0, 0, 0, 32'h300, 0, 2'd0, 32'h304, 0, 32'h200);
        vecs[13] = mk(32'h0,   32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h100, 1, 2'd2, 32'h200, 0, 32'h200);
        vecs[14] = mk(32'h44,  32'h80,  2'b11, 32'h48,  2'd0, 0, 0, 32'h44,  1, 2'd3, 32'h80,  1, 32'h80);
        vecs[15] = mk(32'h0,   32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h44,  1, 2'd3, 32'h80,  0, 32'h80);
        vecs[16] = mk(32'h44,  32'h80,  2'b11, 32'h80,  2'd1, 1, 0, 32'h44,  1, 2'd3, 32'h80,  0, 32'h80);
        vecs[17] = mk(32'h88,  32'h0,   2'b01, 32'h8C,  2'd0, 0, 0, 32'h88,  0, 2'd0, 32'h8C,  0, 32'h80);
        vecs[18] = mk(32'h88,  32'h0,   2'b01, 32'h200, 2'd0, 0, 0, 32'h88,  0, 2'd0, 32'h8C,  1, 32'h8C);
        vecs[19] = mk(32'h0,   32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h88,  0, 2'd0, 32'h8C,  0, 32'h8C);
        vecs[20] = mk(32'hFFFF_FFFC, 32'h0, 2'b01, 32'h0, 2'd0, 0, 0, 32'hFFFF_FFFC, 0, 2'd0, 32'h0, 0, 32'h8C);
        vecs[21] = mk(32'hFFFF_FFFC, 32'h0, 2'b01, 32'h4, 2'd0, 0, 0, 32'hFFFF_FFFC, 0, 2'd0, 32'h0, 1, 32'h0);
        vecs[22] = mk(32'h0,   32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h100, 1, 2'd2, 32'h200, 0, 32'h0);
        vecs[23] = mk(32'h100, 32'h500, 2'b01, 32'h104, 2'd3, 1, 1, 32'h100, 1, 2'd2, 32'h200, 0, 32'h0);
        vecs[24] = mk(32'h100, 32'h600, 2'b10, 32'h200, 2'd2, 1, 1, 32'h100, 1, 2'd3, 32'h600, 1, 32'h600);
        vecs[25] = mk(32'h0,   32'h0,   2'b00, 32'h0,   2'd0, 0, 0, 32'h100, 1, 2'd3, 32'h600, 0, 32'h600);

        reset = 1'b1;
        stg_ena = 1'b1;
        fetch_pc = 32'h100;
        idle_upd();
        tick();
        tick();
        @(negedge stg_clk);
        reset = 1'b0;
        #1;
        chk_pred("reset", 1'b0, 2'd0, 32'h104);
        chk_redir("reset", 1'b0, 32'h0);
        chk_stats("reset", 32'd0, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge stg_clk);
            drive_upd(vecs[i].upc, vecs[i].utgt, vecs[i].uflag, vecs[i].ufpc,
                      vecs[i].ucnt, vecs[i].uval, vecs[i].upred);
            fetch_pc = vecs[i].fpc;
            tick();
            chk_pred($sformatf("vec%0d", i), vecs[i].e_pv, vecs[i].e_cnt, vecs[i].e_next);
            chk_redir($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_rpc);
        end
        chk_stats("table_end", 32'd16, 32'd7);

        // Stall holds an outstanding redirect and blocks an allocating write.
        @(negedge stg_clk);
        drive_upd(32'h88, 32'h0, 2'b01, 32'h0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_redir("stall_pre", 1'b1, 32'h8C);
        @(negedge stg_clk);
        stg_ena = 1'b0;
        drive_upd(32'hCC, 32'h700, 2'b10, 32'hD0, 2'd0, 1'b0, 1'b0);
        fetch_pc = 32'hCC;
        tick();
        chk_redir("stall", 1'b1, 32'h8C);
        chk_pred("stall", 1'b0, 2'd0, 32'hD0);
        @(negedge stg_clk);
        stg_ena = 1'b1;
        idle_upd();
        tick();
        chk_redir("stall_release", 1'b0, 32'h8C);
        chk_pred("stall_release", 1'b0, 2'd0, 32'hD0);
        chk_stats("stall", 32'd17, 32'd8);

        // A lookup in the same cycle as the write sees the old contents.
        @(negedge stg_clk);
        drive_upd(32'hCC, 32'h700, 2'b10, 32'hD0, 2'd0, 1'b0, 1'b0);
        fetch_pc = 32'hCC;
        #1;
        chk_pred("same_cycle", 1'b0, 2'd0, 32'hD0);
        tick();
        chk_pred("after_write", 1'b1, 2'd2, 32'h700);
        chk_redir("after_write", 1'b1, 32'h700);
        chk_stats("after_write", 32'd18, 32'd9);
        @(negedge stg_clk);
        idle_upd();
        tick();
        chk_redir("after_write_clear", 1'b0, 32'h700);

        // Reset wins over a simultaneous allocating update.
        @(negedge stg_clk);
        reset = 1'b1;
        drive_upd(32'h10C, 32'h900, 2'b10, 32'h110, 2'd0, 1'b0, 1'b0);
        fetch_pc = 32'h10C;
        tick();
        chk_pred("reset_upd", 1'b0, 2'd0, 32'h110);
        chk_redir("reset_upd", 1'b0, 32'h0);
        chk_stats("reset_upd", 32'd0, 32'd0);
        fetch_pc = 32'hCC;
        #1;
        chk_pred("reset_cc", 1'b0, 2'd0, 32'hD0);
        fetch_pc = 32'h100;
        #1;
        chk_pred("reset_100", 1'b0, 2'd0, 32'h104);
        @(negedge stg_clk);
        reset = 1'b0;
        idle_upd();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
